// File: rtl/i2c_slave_reg_arbiter_if.sv
// i2c_slave_reg_arbiter_if: bus bundle between the I2C byte engine / local host and the register arbiter.
// Engine side : i2c_wr_stb, i2c_addr, i2c_wdata, i2c_rd_addr, i2c_busy (to arbiter); i2c_rdata, i2c_ovf (from arbiter)
// Host side   : host_req, host_we, host_addr, host_wdata (to arbiter); host_gnt, host_rvalid, host_rdata (from arbiter)
// master drives the requests, slave is the arbiter.
interface i2c_slave_reg_arbiter_if;
  logic       i2c_wr_stb;
  logic [7:0] i2c_addr;
  logic [7:0] i2c_wdata;
  logic [7:0] i2c_rd_addr;
  logic       i2c_busy;
  logic [7:0] i2c_rdata;
  logic       i2c_ovf;
  logic       host_req;
  logic       host_we;
  logic [7:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_gnt;
  logic       host_rvalid;
  logic [7:0] host_rdata;
  modport master (
    output i2c_wr_stb, i2c_addr, i2c_wdata, i2c_rd_addr, i2c_busy,
    output host_req, host_we, host_addr, host_wdata,
    input  i2c_rdata, i2c_ovf, host_gnt, host_rvalid, host_rdata
  );
  modport slave (
    input  i2c_wr_stb, i2c_addr, i2c_wdata, i2c_rd_addr, i2c_busy,
    input  host_req, host_we, host_addr, host_wdata,
    output i2c_rdata, i2c_ovf, host_gnt, host_rvalid, host_rdata
  );
endinterface

// File: rtl/i2c_slave_reg_arbiter.sv
// i2c_slave_reg_arbiter: single-port register bank shared by an I2C byte engine and a host, one access slot per clk.
// Ports: clk, rst_n (async, active-low); io_bus (slave modport) carries the engine write strobe/address/data,
// the engine read address and busy flag, the prefetched read byte and sticky overflow, and the host
// request/grant/read-data handshake.
module i2c_slave_reg_arbiter #(
  parameter int         ADDR_W       = 8,
  parameter logic [7:0] RESET_VAL    = 8'h00,
  parameter bit         LOCK_HOST_WR = 1'b1
) (
  input logic clk,
  input logic rst_n,
  i2c_slave_reg_arbiter_if.slave io_bus
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic [2:0] {S_IDLE, S_PREFETCH, S_I2C_WR, S_HOST_WR, S_HOST_RD} slot_t;
  slot_t             r_state, w_next;
  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_trk, r_wr_addr, w_rd_addr, w_host_addr, w_waddr;
  logic [7:0]        r_wr_data, r_rdata, r_hrdata, w_wdata;
  logic              r_wr_pend, r_rd_pend, r_ovf, r_rvalid, r_rr_host;
  logic              w_host_ok, w_is_wr;
  assign w_rd_addr   = io_bus.i2c_rd_addr[ADDR_W-1:0];
  assign w_host_addr = io_bus.host_addr[ADDR_W-1:0];
  assign w_host_ok   = io_bus.host_req && (!io_bus.host_we || !(LOCK_HOST_WR && io_bus.i2c_busy));
  // The slot entered at an edge is also the access committed on that edge; the state register then
  // shows which slot just ran, which is what host_gnt reports.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  // Prefetch first, then round-robin between the buffered I2C write and an eligible host request.
  always_comb begin
    w_next = S_IDLE;
    if (r_rd_pend)
      w_next = S_PREFETCH;
    else if (r_wr_pend && (!w_host_ok || r_rr_host))
      w_next = S_I2C_WR;
    else if (w_host_ok)
      w_next = io_bus.host_we ? S_HOST_WR : S_HOST_RD;
  end
  always_comb begin
    io_bus.host_gnt    = r_state == S_HOST_WR || r_state == S_HOST_RD;
    io_bus.host_rvalid = r_rvalid;
    io_bus.host_rdata  = r_hrdata;
    io_bus.i2c_rdata   = r_rdata;
    io_bus.i2c_ovf     = r_ovf;
  end
  assign w_is_wr = w_next == S_I2C_WR || w_next == S_HOST_WR;
  assign w_waddr = w_next == S_I2C_WR ? r_wr_addr : w_host_addr;
  assign w_wdata = w_next == S_I2C_WR ? r_wr_data : io_bus.host_wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= RESET_VAL;
      r_rdata   <= RESET_VAL;
      r_ovf     <= 1'b0;
      r_rvalid  <= 1'b0;
      r_hrdata  <= 8'h00;
      r_wr_pend <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= 8'h00;
      r_rd_pend <= 1'b1;
      r_rr_host <= 1'b1;
      r_trk     <= '0;
    end else begin
      if (w_is_wr) r_mem[w_waddr] <= w_wdata;
      // A write landing on the tracked address refreshes the prefetched byte directly.
      if (w_next == S_PREFETCH)            r_rdata <= r_mem[r_trk];
      else if (w_is_wr && w_waddr == r_trk) r_rdata <= w_wdata;
      if (w_next == S_HOST_RD) r_hrdata <= r_mem[w_host_addr];
      r_rvalid  <= r_state == S_HOST_RD;
      r_trk     <= w_rd_addr;
      r_rd_pend <= (w_rd_addr != r_trk) || (r_rd_pend && w_next != S_PREFETCH);
      if (io_bus.i2c_wr_stb) begin
        r_wr_addr <= io_bus.i2c_addr[ADDR_W-1:0];
        r_wr_data <= io_bus.i2c_wdata;
      end
      // A strobe is lost only if the buffered byte is not committed on this same edge.
      r_wr_pend <= io_bus.i2c_wr_stb || (r_wr_pend && w_next != S_I2C_WR);
      r_ovf     <= r_ovf || (io_bus.i2c_wr_stb && r_wr_pend && w_next != S_I2C_WR);
      if (w_is_wr || w_next == S_HOST_RD) r_rr_host <= w_next != S_I2C_WR;
    end
endmodule
